// File: rtl/spi_panel_slave.sv
// spi_panel_slave: SCLK-only SPI slave driving LED ports and returning switch/ID/ACK/NAK responses.
// Define SPI_BURST_EN to stream data words with an auto-incrementing port index.
module spi_panel_slave #(
  parameter int         WORD_W    = 8,
  parameter int         NUM_OUT   = 4,
  parameter int         NUM_IN    = 2,
  parameter int         LSB_FIRST = 1,
  parameter logic [7:0] CHIP_ID   = 8'h72,
  parameter logic [7:0] VENDOR_ID = 8'hAE,
  parameter logic [7:0] ACK       = 8'h01,
  parameter logic [7:0] NAK       = 8'h80
) (
  input  logic                      SCLK,
  input  logic                      NRST,
  input  logic                      SS,
  input  logic                      MOSI,
  output logic                      MISO,
  output logic [NUM_OUT*WORD_W-1:0] OUTPORTS,
  input  logic [NUM_IN*WORD_W-1:0]  INPORTS,
  output logic                      WORD_STB
);
  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);
  typedef enum logic {CMD, DATA} state_t;
  state_t                    r_state, w_state_nx;
  logic [CW-1:0]             r_bitcnt, w_sel;
  logic [WORD_W-2:0]         r_rx;
  logic [WORD_W-1:0]         r_tx, w_word, w_resp_cmd, w_tx_nx;
  logic [NUM_OUT*WORD_W-1:0] r_out;
  logic [3:0]                r_devcmd, r_idx, w_idx_nx;
  logic                      w_done, w_wr;

  function automatic logic [WORD_W-1:0] resp(input logic [3:0] op, input logic [3:0] idx);
    logic [WORD_W-1:0] v;
    v = WORD_W'(NAK);
    case (op)
      4'h0: v = WORD_W'(ACK);
      4'h1: if ({1'b0, idx} < 5'(NUM_OUT)) v = WORD_W'(ACK);
      4'h2: for (int k = 0; k < NUM_IN; k++) if (idx == 4'(k)) v = INPORTS[k*WORD_W +: WORD_W];
      4'h3: for (int k = 0; k < NUM_OUT; k++) if (idx == 4'(k)) v = r_out[k*WORD_W +: WORD_W];
      4'h6: v = WORD_W'(CHIP_ID);
      4'h9: v = WORD_W'(VENDOR_ID);
      default: ;
    endcase
    return v;
  endfunction

  // The completed word includes the bit arriving on the current edge.
  assign w_word     = (LSB_FIRST != 0) ? {MOSI, r_rx} : {r_rx, MOSI};
  assign w_sel      = (LSB_FIRST != 0) ? r_bitcnt : LAST - r_bitcnt;
  assign w_done     = !SS && (r_bitcnt == LAST);
  assign w_resp_cmd = resp(w_word[7:4], w_word[3:0]);
  assign w_wr       = w_done && r_state == DATA && r_devcmd == 4'h1 && ({1'b0, r_idx} < 5'(NUM_OUT));
  assign OUTPORTS   = r_out;

`ifdef SPI_BURST_EN
  logic [4:0] w_lim;
  logic       w_legal;
  always_comb begin
    w_lim      = (r_devcmd == 4'h2) ? 5'(NUM_IN) : 5'(NUM_OUT);
    w_legal    = (r_devcmd inside {4'h1, 4'h2, 4'h3}) && ({1'b0, r_idx} < w_lim);
    w_idx_nx   = !w_legal ? r_idx : ({1'b0, r_idx} + 5'd1 == w_lim) ? 4'd0 : r_idx + 4'd1;
    w_state_nx = !w_done ? r_state :
                 (r_state == CMD || !(r_devcmd == 4'h0 && w_word == '0)) ? DATA : CMD;
    w_tx_nx    = (w_state_nx == DATA) ? resp(r_devcmd, w_idx_nx) : '0;
  end
`else
  always_comb begin
    w_state_nx = !w_done ? r_state : (r_state == CMD) ? DATA : CMD;
    w_idx_nx   = r_idx;
    w_tx_nx    = '0;
  end
`endif

  always_ff @(posedge SCLK or posedge NRST)
    if (NRST) r_state <= CMD;
    else r_state <= w_state_nx;

  always_ff @(posedge SCLK or posedge NRST) begin
    if (NRST) begin
      r_bitcnt <= '0;
      r_rx     <= '0;
      r_tx     <= '0;
      r_devcmd <= '0;
      r_idx    <= '0;
      r_out    <= '0;
      WORD_STB <= 1'b0;
    end else begin
      WORD_STB <= w_done;
      if (!SS) begin
        r_bitcnt <= w_done ? '0 : r_bitcnt + CW'(1);
        r_rx     <= (LSB_FIRST != 0) ? w_word[WORD_W-1:1] : w_word[WORD_W-2:0];
      end
      if (w_done && r_state == CMD) begin
        r_tx     <= w_resp_cmd;
        r_devcmd <= w_word[7:4];
        r_idx    <= w_word[3:0];
      end
      if (w_done && r_state == DATA) begin
        r_tx  <= w_tx_nx;
        r_idx <= w_idx_nx;
      end
      for (int k = 0; k < NUM_OUT; k++)
        if (w_wr && r_idx == 4'(k)) r_out[k*WORD_W +: WORD_W] <= w_word;
    end
  end

  // Response bits launch on the falling edge so the master can sample on the rising edge.
  always_ff @(negedge SCLK or posedge NRST)
    if (NRST) MISO <= 1'b0;
    else if (!SS) MISO <= r_tx[w_sel];
endmodule

// File: tb/tb_spi_panel_slave.sv
// tb_spi_panel_slave: directed bench for an 8-bit LSB-first slave and a 16-bit MSB-first slave.
module tb_spi_panel_slave;
  logic        sclk = 1'b1, nrst = 1'b0, ss_a = 1'b1, ss_b = 1'b1, mosi = 1'b0;
  logic        miso_a, miso_b, stb_a, stb_b;
  logic [31:0] out_a;
  logic [15:0] in_a = 16'h3C5A;
  logic [63:0] out_b;
  logic [31:0] in_b = 32'h1234_5678;
  logic [15:0] r, m;
  int          vecs = 0, errs = 0;

  spi_panel_slave dut_a (
    .SCLK(sclk), .NRST(nrst), .SS(ss_a), .MOSI(mosi), .MISO(miso_a),
    .OUTPORTS(out_a), .INPORTS(in_a), .WORD_STB(stb_a));

  spi_panel_slave #(.WORD_W(16), .LSB_FIRST(0)) dut_b (
    .SCLK(sclk), .NRST(nrst), .SS(ss_b), .MOSI(mosi), .MISO(miso_b),
    .OUTPORTS(out_b), .INPORTS(in_b), .WORD_STB(stb_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Idle-high clock: MISO launches on the falling edge, MOSI is taken on the rising edge.
  task automatic xfer(input bit b, input logic [15:0] w, input int nb,
                      output logic [15:0] rd, output logic [15:0] sm);
    rd = '0;
    sm = '0;
    for (int i = 0; i < nb; i++) begin
      int p;
      p = b ? nb - 1 - i : i;
      mosi = w[p];
      #5 sclk = 1'b0;
      #4 rd[p] = b ? miso_b : miso_a;
      #1 sclk = 1'b1;
      #1 sm[i] = b ? stb_b : stb_a;
      #4;
    end
  endtask

  task automatic tx_a(input logic [7:0] w, input logic [7:0] exp, input string tag);
    logic [15:0] rd, sm;
    xfer(1'b0, {8'h00, w}, 8, rd, sm);
    chk(tag, rd, {8'h00, exp});
    chk({tag, "_stb"}, sm, 16'h0080);
  endtask

  task automatic tx_b(input logic [15:0] w, input logic [15:0] exp, input string tag);
    logic [15:0] rd, sm;
    xfer(1'b1, w, 16, rd, sm);
    chk(tag, rd, exp);
    chk({tag, "_stb"}, sm, 16'h8000);
  endtask

  task automatic rst_pulse();
    nrst = 1'b1;
    #2 nrst = 1'b0;
    #3;
  endtask

  initial begin
    #1 nrst = 1'b1;
    #2;
    chk("rst_miso_a", miso_a, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_stb_a", stb_a, 0);
    chk("rst_miso_b", miso_b, 0);
    chk("rst_out_b", out_b, 0);
    nrst = 1'b0;
    #5 ss_b = 1'b0;
    #5;
    tx_b(16'h0090, 16'h0000, "b_ven_cmd");
    tx_b(16'h0000, 16'h00AE, "b_vendor");
`ifdef SPI_BURST_EN
    tx_b(16'h0000, 16'h00AE, "b_vendor_burst");
    ss_b = 1'b1;
    #5 ss_a = 1'b0;
    #5;
    tx_a(8'h60, 8'h00, "id_cmd");
    tx_a(8'h00, 8'h72, "chip_id");
    tx_a(8'h55, 8'h72, "chip_id_again");
    rst_pulse();
    tx_a(8'h13, 8'h00, "bw_cmd");
    tx_a(8'h11, 8'h01, "bw_p3");
    tx_a(8'h22, 8'h01, "bw_p0");
    tx_a(8'h33, 8'h01, "bw_p1");
    chk("bw_out", out_a, 32'h1100_3322);
    xfer(1'b0, 16'h0007, 3, r, m);
    rst_pulse();
    chk("midword_rst_out", out_a, 0);
    tx_a(8'h17, 8'h00, "bad_start_cmd");
    tx_a(8'hFF, 8'h80, "bad_start_1");
    tx_a(8'hFF, 8'h80, "bad_start_2");
    chk("bad_start_out", out_a, 0);
    rst_pulse();
    tx_a(8'h00, 8'h00, "nop_cmd");
    tx_a(8'h05, 8'h01, "nop_data");
    tx_a(8'h00, 8'h01, "nop_end");
    tx_a(8'h90, 8'h00, "ven_cmd");
    tx_a(8'h00, 8'hAE, "vendor_after_nop");
`else
    tx_b(16'h5A60, 16'h0000, "b_chip_cmd_hi");
    tx_b(16'h0000, 16'h0072, "b_chip_hi_ignored");
    tx_b(16'h0011, 16'h0000, "b_wr_cmd");
    tx_b(16'hBEEF, 16'h0001, "b_wr_ack");
    chk("b_wr_out", out_b, 64'h0000_0000_BEEF_0000);
    tx_b(16'h0020, 16'h0000, "b_rd_cmd");
    tx_b(16'h0000, 16'h5678, "b_rd_in0");
    ss_b = 1'b1;
    #5 ss_a = 1'b0;
    #5;
    tx_a(8'h60, 8'h00, "id_cmd");
    tx_a(8'h00, 8'h72, "chip_id");
    tx_a(8'h12, 8'h00, "wr_cmd");
    tx_a(8'hA5, 8'h01, "wr_ack");
    chk("wr_out", out_a, 32'h00A5_0000);
    tx_a(8'h21, 8'h00, "rd_in_cmd");
    tx_a(8'h00, 8'h3C, "rd_in1");
    tx_a(8'h25, 8'h00, "rd_in_bad_cmd");
    tx_a(8'h00, 8'h80, "rd_in_nak");
    tx_a(8'h17, 8'h00, "wr_bad_cmd");
    tx_a(8'hFF, 8'h80, "wr_nak");
    chk("wr_dropped", out_a, 32'h00A5_0000);
    tx_a(8'hF0, 8'h00, "bad_op_cmd");
    tx_a(8'h00, 8'h80, "bad_op");
    tx_a(8'h32, 8'h00, "rd_out_cmd");
    tx_a(8'h00, 8'hA5, "rd_out2");
    tx_a(8'h00, 8'h00, "nop_cmd");
    tx_a(8'h00, 8'h01, "nop");
    xfer(1'b0, 16'h0007, 3, r, m);
    rst_pulse();
    chk("midword_rst_out", out_a, 0);
    chk("midword_rst_miso", miso_a, 0);
    tx_a(8'h13, 8'h00, "wr3_cmd");
    tx_a(8'h11, 8'h01, "wr3_ack");
    tx_a(8'h22, 8'h00, "rd_in2_cmd");
    tx_a(8'h33, 8'h80, "rd_in2_nak");
    chk("wr3_out", out_a, 32'h1100_0000);
`endif
    ss_a = 1'b1;
    #10;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
